// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Round-robin arbiter sharing one memory port between fetch and data requesters
//
// Purpose:
//   Two requesters (instruction fetch, data load/store) share one memory port.
//   An IDLE/ACCESS FSM accepts one request at a time and picks between
//   simultaneous requests by round robin. It then holds the memory port for
//   ACCESS_CYCLES cycles and pulses the owner's response one cycle after the
//   last access cycle.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   if_req_valid_i/if_addr_i   fetch request in
//   if_req_ready_o             fetch request accepted this cycle (combinational)
//   if_resp_valid_o/if_rdata_o fetch response pulse and held read data
//   d_req_valid_i/d_addr_i/d_wdata_i/d_we_i/d_funct3_i
//                              data request in (we=1 store, funct3 size code)
//   d_req_ready_o              data request accepted this cycle (combinational)
//   d_resp_valid_o/d_rdata_o   data response pulse and held load data
//   mem_addr_o/mem_data_o/mem_read_en_o/mem_write_en_o/mem_funct3_o
//                              shared memory port, all zero outside ACCESS
//   mem_rdata_i                combinational memory read data

module mem_arbiter #(
    parameter int AWIDTH        = 32,
    parameter int DWIDTH        = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_req_ready_o,
    output logic              if_resp_valid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              d_req_valid_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic              d_we_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_req_ready_o,
    output logic              d_resp_valid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    generate
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
            $error("mem_arbiter: ACCESS_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LP_CNT_INIT = 4'(ACCESS_CYCLES - 1);
    localparam logic [2:0] LP_FETCH_F3 = 3'b010;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_prefer_d;   // 1: data wins the next tie
    logic              r_owner_d;    // 1: current transaction belongs to data side
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [DWIDTH-1:0] r_if_rdata;
    logic [DWIDTH-1:0] r_d_rdata;
    logic              r_if_resp;
    logic              r_d_resp;

    logic w_idle;
    logic w_access;
    logic w_last;
    logic w_if_grant;
    logic w_d_grant;

    // Gating with rst keeps the ready outputs low while reset is held,
    // even though they are combinational from the valid inputs.
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign w_access   = (r_state == ST_ACCESS);
    assign w_last     = w_access && (r_cnt == 4'd0);
    assign w_if_grant = w_idle && if_req_valid_i && (!d_req_valid_i || !r_prefer_d);
    assign w_d_grant  = w_idle && d_req_valid_i && (!if_req_valid_i || r_prefer_d);

    assign if_req_ready_o  = w_if_grant;
    assign d_req_ready_o   = w_d_grant;
    assign if_resp_valid_o = r_if_resp;
    assign d_resp_valid_o  = r_d_resp;
    assign if_rdata_o      = r_if_rdata;
    assign d_rdata_o       = r_d_rdata;

    assign mem_addr_o     = w_access ? r_addr : '0;
    assign mem_data_o     = w_access ? r_wdata : '0;
    assign mem_funct3_o   = w_access ? r_funct3 : 3'b000;
    assign mem_read_en_o  = w_access && !r_we;
    // A store only strobes on its last cycle so memory sees a single write edge.
    assign mem_write_en_o = w_last && r_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_prefer_d <= 1'b0;
            r_owner_d  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_resp  <= 1'b0;
            r_d_resp   <= 1'b0;
        end else begin
            r_if_resp <= 1'b0;
            r_d_resp  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_if_grant) begin
                        r_addr     <= if_addr_i;
                        r_wdata    <= '0;
                        r_we       <= 1'b0;
                        r_funct3   <= LP_FETCH_F3;
                        r_owner_d  <= 1'b0;
                        r_prefer_d <= 1'b1;
                        r_cnt      <= LP_CNT_INIT;
                        r_state    <= ST_ACCESS;
                    end else if (w_d_grant) begin
                        r_addr     <= d_addr_i;
                        r_wdata    <= d_wdata_i;
                        r_we       <= d_we_i;
                        r_funct3   <= d_funct3_i;
                        r_owner_d  <= 1'b1;
                        r_prefer_d <= 1'b0;
                        r_cnt      <= LP_CNT_INIT;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        if (r_owner_d) begin
                            r_d_resp <= 1'b1;
                            if (!r_we) begin
                                r_d_rdata <= mem_rdata_i;
                            end
                        end else begin
                            r_if_resp  <= 1'b1;
                            r_if_rdata <= mem_rdata_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter against a transaction-window reference model

module tb_mem_arbiter;

    localparam int AC = 3;

    logic        clk;
    logic        rst;
    logic        if_req_valid_i;
    logic [31:0] if_addr_i;
    logic        if_req_ready_o;
    logic        if_resp_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_valid_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_we_i;
    logic [2:0]  d_funct3_i;
    logic        d_req_ready_o;
    logic        d_resp_valid_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_rdata_i;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid_i(if_req_valid_i), .if_addr_i(if_addr_i),
        .if_req_ready_o(if_req_ready_o), .if_resp_valid_o(if_resp_valid_o),
        .if_rdata_o(if_rdata_o),
        .d_req_valid_i(d_req_valid_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_we_i(d_we_i), .d_funct3_i(d_funct3_i),
        .d_req_ready_o(d_req_ready_o), .d_resp_valid_o(d_resp_valid_o),
        .d_rdata_o(d_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_funct3_o(mem_funct3_o), .mem_rdata_i(mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a transaction owns the port for the AC cycles that
    // follow its accept edge; m_left counts how many of those remain.
    int          m_left;
    logic        m_prefer_d;
    logic        m_owner_d;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_if_rdata, m_d_rdata;
    logic        m_if_resp, m_d_resp;

    // Values seen in the most recent step, for directed timeline checks.
    logic        obs_if_rdy, obs_d_rdy, obs_if_resp, obs_d_resp, obs_re, obs_we;
    logic [31:0] obs_if_rdata, obs_d_rdata;

    task automatic model_reset();
        m_left = 0; m_prefer_d = 1'b0; m_owner_d = 1'b0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_f3 = 3'b000;
        m_if_rdata = '0; m_d_rdata = '0; m_if_resp = 1'b0; m_d_resp = 1'b0;
    endtask

    // Drive one cycle of inputs, check every output against the model, clock, update model.
    task automatic step(input logic rst_v, input logic ifv, input logic [31:0] ifa,
                        input logic dv, input logic [31:0] da, input logic [31:0] dwd,
                        input logic dwe, input logic [2:0] df3, input logic [31:0] mrd,
                        output logic acc_if, output logic acc_d);
        logic        idle, busy, last;
        rst = rst_v;
        if_req_valid_i = ifv; if_addr_i = ifa;
        d_req_valid_i = dv; d_addr_i = da; d_wdata_i = dwd; d_we_i = dwe; d_funct3_i = df3;
        mem_rdata_i = mrd;
        #1;
        if (rst_v) model_reset();
        idle   = (m_left == 0) && !rst_v;
        busy   = (m_left > 0);
        last   = (m_left == 1);
        acc_if = idle && ifv && (!dv || !m_prefer_d);
        acc_d  = idle && dv && !acc_if;

        obs_if_rdy = if_req_ready_o; obs_d_rdy = d_req_ready_o;
        obs_if_resp = if_resp_valid_o; obs_d_resp = d_resp_valid_o;
        obs_re = mem_read_en_o; obs_we = mem_write_en_o;
        obs_if_rdata = if_rdata_o; obs_d_rdata = d_rdata_o;

        check_eq("if_ready", if_req_ready_o, acc_if);
        check_eq("d_ready", d_req_ready_o, acc_d);
        check_eq("ready_excl", if_req_ready_o & d_req_ready_o, 0);
        check_eq("if_resp", if_resp_valid_o, m_if_resp);
        check_eq("if_rdata", if_rdata_o, m_if_rdata);
        check_eq("d_resp", d_resp_valid_o, m_d_resp);
        check_eq("d_rdata", d_rdata_o, m_d_rdata);
        check_eq("mem_addr", mem_addr_o, busy ? m_addr : 32'h0);
        check_eq("mem_data", mem_data_o, busy ? m_wdata : 32'h0);
        check_eq("mem_f3", mem_funct3_o, busy ? m_f3 : 3'b000);
        check_eq("mem_re", mem_read_en_o, busy && !m_we);
        check_eq("mem_we", mem_write_en_o, last && m_we);

        @(posedge clk);
        if (!rst_v) begin
            m_if_resp = 1'b0;
            m_d_resp  = 1'b0;
            if (last) begin
                if (m_owner_d) begin
                    m_d_resp = 1'b1;
                    if (!m_we) m_d_rdata = mrd;
                end else begin
                    m_if_resp  = 1'b1;
                    m_if_rdata = mrd;
                end
            end
            if (busy) begin
                m_left--;
            end else if (acc_if) begin
                m_left = AC; m_owner_d = 1'b0; m_prefer_d = 1'b1;
                m_addr = ifa; m_wdata = '0; m_we = 1'b0; m_f3 = 3'b010;
            end else if (acc_d) begin
                m_left = AC; m_owner_d = 1'b1; m_prefer_d = 1'b0;
                m_addr = da; m_wdata = dwd; m_we = dwe; m_f3 = df3;
            end
        end
        #1;
    endtask

    logic a_if, a_d;
    int   n_resp, n_coinc;

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, $urandom, a_if, a_d);
    endtask

    // Random-stimulus pending requests (held until accepted).
    logic        p_if, p_d, p_dwe;
    logic [31:0] p_ifa, p_da, p_dwd;
    logic [2:0]  p_df3;

    initial begin
        model_reset();
        rst = 1'b1;
        if_req_valid_i = 1'b0; if_addr_i = '0;
        d_req_valid_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_we_i = 1'b0; d_funct3_i = 3'b000;
        mem_rdata_i = '0;
        @(posedge clk); #1;

        // Reset held with both requesters valid: everything must stay zero.
        step(1'b1, 1'b1, 32'h1234, 1'b1, 32'h5678, 32'hFFFF, 1'b1, 3'b111, 32'hFFFF_FFFF, a_if, a_d);
        check_eq("rst_if_rdy", obs_if_rdy, 0);
        check_eq("rst_d_rdy", obs_d_rdy, 0);

        // Single fetch: accept, AC read cycles, then response with the memory word.
        step(1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, a_if, a_d);
        check_eq("f_accept", obs_if_rdy, 1);
        for (int i = 0; i < AC; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0000_0293, a_if, a_d);
            check_eq("f_read_en", obs_re, 1);
            check_eq("f_no_resp", obs_if_resp, 0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, a_if, a_d);
        check_eq("f_resp", obs_if_resp, 1);
        check_eq("f_rdata", obs_if_rdata, 32'h0000_0293);

        // Both valid after reset: fetch first, then alternate.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, a_if, a_d);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 32'h0100_0100 + k, 1'b1, 32'h0200_0000 + k, 32'h0, 1'b0, 3'b010, $urandom, a_if, a_d);
            check_eq("rr_if", obs_if_rdy, (k % 2) == 0);
            check_eq("rr_d", obs_d_rdy, (k % 2) == 1);
            for (int i = 0; i < AC; i++)
                step(1'b0, 1'b1, 32'h0100_0100 + k + 1, 1'b1, 32'h0200_0000 + k + 1, 32'h0, 1'b0, 3'b010, $urandom, a_if, a_d);
        end
        idle_steps(AC + 1);

        // Store: write enable only in the last access cycle, rdata untouched.
        begin
            logic [31:0] d_before;
            step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'h0, a_if, a_d);
            check_eq("st_accept", obs_d_rdy, 1);
            d_before = obs_d_rdata;
            for (int i = 0; i < AC; i++) begin
                step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h5555_AAAA, a_if, a_d);
                check_eq("st_we", obs_we, i == AC - 1);
                check_eq("st_re", obs_re, 0);
            end
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, a_if, a_d);
            check_eq("st_resp", obs_d_resp, 1);
            check_eq("st_rdata_hold", obs_d_rdata, d_before);
        end

        // Reset in the second cycle of a store aborts it.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0100_0020, 32'h1111_2222, 1'b1, 3'b010, 32'h0, a_if, a_d);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, a_if, a_d);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 32'h0, a_if, a_d);
        check_eq("ab_we", obs_we, 0);
        step(1'b0, 1'b1, 32'h0100_0040, 1'b1, 32'h0100_0044, 32'h0, 1'b0, 3'b010, 32'h0, a_if, a_d);
        check_eq("ab_if_rdy", obs_if_rdy, 1);
        check_eq("ab_d_resp", obs_d_resp, 0);
        check_eq("ab_we2", obs_we, 0);
        idle_steps(AC + 1);

        // Continuous fetch: one response per AC+1 cycles, each coinciding with a new accept.
        n_resp = 0; n_coinc = 0;
        for (int i = 0; i < 4 * (AC + 1); i++) begin
            step(1'b0, 1'b1, 32'h0100_1000 + 4 * i, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, $urandom, a_if, a_d);
            if (obs_if_resp) n_resp++;
            if (obs_if_resp && obs_if_rdy) n_coinc++;
        end
        check_eq("cf_resp_cnt", n_resp, 3);
        check_eq("cf_coincide", n_coinc, 3);
        idle_steps(AC + 1);

        // Randomized traffic against the model, with occasional resets.
        p_if = 1'b0; p_d = 1'b0;
        p_ifa = '0; p_da = '0; p_dwd = '0; p_dwe = 1'b0; p_df3 = 3'b000;
        for (int c = 0; c < 600; c++) begin
            logic rr;
            if (!p_if && ($urandom_range(0, 2) == 0)) begin
                p_if = 1'b1; p_ifa = $urandom;
            end
            if (!p_d && ($urandom_range(0, 2) == 0)) begin
                p_d = 1'b1; p_da = $urandom; p_dwd = $urandom;
                p_dwe = 1'($urandom_range(0, 1)); p_df3 = 3'($urandom_range(0, 7));
            end
            rr = ($urandom_range(0, 99) == 0);
            step(rr, p_if, p_ifa, p_d, p_da, p_dwd, p_dwe, p_df3, $urandom, a_if, a_d);
            if (a_if) p_if = 1'b0;
            if (a_d) p_d = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
